// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: port identifiers, read-return tag and the address legality check
// shared by dmem_arbiter and its read-return pipeline.
package dmem_arb_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_AUX = 1'b1;

    typedef struct packed {
        logic     valid;
        port_id_t port;
        logic     err;
    } rd_tag_t;

    // Illegal when not word aligned or when any byte-address bit above the word index is set.
    function automatic logic addr_err(input logic [31:0] addr, input int aw);
        logic [31:0] upper;
        upper = addr >> (aw + 2);
        return (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rd_return_pipe.sv
// rd_return_pipe: RD_LAT-deep shift register carrying one read tag per accepted read,
// aligned with the RAM read latency.
module rd_return_pipe
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [RD_LAT];
    rd_tag_t stage_d [RD_LAT];

    // Next-state: new tag enters stage 0, older tags move one stage on.
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-port data RAM between the CPU (port 0)
// and an auxiliary master (port 1). Define DMEM_ARB_PERF_EN to add the perf counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [31:0]   m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [31:0]   m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_gnt0,
    output logic [31:0]   perf_gnt1,
    output logic [31:0]   perf_conflict
`endif
);

    port_id_t      last_gnt_q;
    port_id_t      last_gnt_d;
    logic          gnt0_s;
    logic          gnt1_s;
    logic          any_gnt_s;
    logic          err_s;
    port_id_t      sel_port_s;
    logic          sel_we_s;
    logic [31:0]   sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    rd_tag_t       tag_in_s;
    rd_tag_t       tag_out_s;

    // Grant: a lone requester wins; on conflict the port that did not win last time goes.
    always_comb begin
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            gnt0_s = m0_req && (!m1_req || (last_gnt_q == PORT_AUX));
            gnt1_s = m1_req && (!m0_req || (last_gnt_q == PORT_CPU));
        end
        any_gnt_s   = gnt0_s || gnt1_s;
        sel_port_s  = gnt1_s ? PORT_AUX : PORT_CPU;
        sel_we_s    = gnt1_s ? m1_we    : m0_we;
        sel_addr_s  = gnt1_s ? m1_addr  : m0_addr;
        sel_wdata_s = gnt1_s ? m1_wdata : m0_wdata;
        err_s       = any_gnt_s && addr_err(sel_addr_s, AW);
        // Rejected accesses leave the fairness pointer alone.
        last_gnt_d     = (any_gnt_s && !err_s) ? sel_port_s : last_gnt_q;
        tag_in_s.valid = any_gnt_s && !sel_we_s;
        tag_in_s.port  = sel_port_s;
        tag_in_s.err   = err_s;
    end

    // Round-robin pointer; after reset port 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= PORT_AUX;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    rd_return_pipe #(.RD_LAT(RD_LAT)) u_rd_return_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    assign mem_en    = any_gnt_s && !err_s;
    assign mem_we    = mem_en && sel_we_s;
    assign mem_addr  = mem_en ? sel_addr_s[AW+1:2] : '0;
    assign mem_wdata = mem_en ? sel_wdata_s : '0;

    assign m0_gnt = gnt0_s;
    assign m1_gnt = gnt1_s;
    assign m0_err = gnt0_s && err_s;
    assign m1_err = gnt1_s && err_s;

    // Return data is steered to the tagged port only; rejected reads return zero.
    assign m0_rvalid = !reset && tag_out_s.valid && (tag_out_s.port == PORT_CPU);
    assign m1_rvalid = !reset && tag_out_s.valid && (tag_out_s.port == PORT_AUX);
    assign m0_rdata  = (m0_rvalid && !tag_out_s.err) ? mem_rdata : '0;
    assign m1_rdata  = (m1_rvalid && !tag_out_s.err) ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_gnt0_q;
    logic [31:0] perf_gnt0_d;
    logic [31:0] perf_gnt1_q;
    logic [31:0] perf_gnt1_d;
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_conflict_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters.
    always_comb begin
        perf_gnt0_d     = gnt0_s ? sat_inc(perf_gnt0_q) : perf_gnt0_q;
        perf_gnt1_d     = gnt1_s ? sat_inc(perf_gnt1_q) : perf_gnt1_q;
        perf_conflict_d = (m0_req && m1_req) ? sat_inc(perf_conflict_q) : perf_conflict_q;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_gnt0_q     <= 32'd0;
            perf_gnt1_q     <= 32'd0;
            perf_conflict_q <= 32'd0;
        end else begin
            perf_gnt0_q     <= perf_gnt0_d;
            perf_gnt1_q     <= perf_gnt1_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_gnt0     = perf_gnt0_q;
    assign perf_gnt1     = perf_gnt1_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data RAM between two masters: port 0 = CPU load/store path, port 1 = auxiliary master (program loader / display reader).
- Sits between the CPU's DataAdr/WriteData/MemWrite/ReadData interface and the data memory.
- Performs at most one memory access per cycle.
- Uses round-robin arbitration, a fixed-latency read-return pipeline, and an address/alignment error check.

Parameters:
- DW, 32, data width in bits.
- AW, 10, word-address width; memory holds 2**AW words.
- RD_LAT, 1, RAM read latency in cycles; legal values 1..3.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  CPU access request
- m0_we  in  1  CPU write enable (1 = store)
- m0_addr  in  32  CPU byte address
- m0_wdata  in  DW  CPU store data
- m0_gnt  out  1  request accepted this cycle
- m0_rvalid  out  1  read data / error valid
- m0_rdata  out  DW  read data
- m0_err  out  1  out-of-range or misaligned access; valid with m0_gnt
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0_*, auxiliary master
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write strobe
- mem_addr  out  AW  RAM word address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, RD_LAT cycles after mem_en

Behaviour:
- Reset: last_gnt=1 (port 0 wins the first conflict); return pipeline cleared. All outputs are 0 during and after reset until a request arrives. Reset mid-operation discards in-flight reads; no rvalid is produced for them.
- Grant (combinational from req and registered last_gnt):
  - one requester → it is granted;
  - both requesting → the port not equal to last_gnt is granted;
  - last_gnt updates only on a granted, error-free cycle.
- Handshake:
  - Request is accepted in the cycle req && gnt.
  - Master holds req/we/addr/wdata stable until gnt.
  - Master may deassert req without a gnt; no effect.
  - Back-to-back grants to the same port are allowed when the other port is idle.
- Error check:
  - err when addr[1:0] != 0, or addr[31:AW+2] != 0.
  - An erroring request is granted with err=1 the same cycle; mem_en stays 0 (no RAM access, no write).
  - A read that errors still returns m*_rvalid RD_LAT cycles later with rdata=0.
  - Erroring requests do not update last_gnt.
- Memory drive:
  - mem_en=1 on a granted, error-free cycle.
  - mem_we=m*_we; mem_addr=addr[AW+1:2]; mem_wdata=m*_wdata of the granted port.
  - Otherwise all mem_* outputs are 0.
- Read return:
  - A RD_LAT-deep shift register carries {valid, port, err} per accepted read.
  - At its output: the matching m*_rvalid=1 for exactly 1 cycle; m*_rdata=mem_rdata (0 if err).
  - Non-matching port sees rvalid=0 and rdata=0.
  - Writes produce no rvalid; write completion = gnt.
- Throughput:
  - One access per cycle sustained.
  - Under continuous conflict, grants strictly alternate 0,1,0,1.
  - Read-after-write to the same address on consecutive cycles returns the new data (RAM is write-first).

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined: adds outputs perf_gnt0, perf_gnt1, perf_conflict (32 bits each).
  - perf_gnt0 / perf_gnt1 count accepted requests per port.
  - perf_conflict counts cycles with both req high.
  - Counters saturate at 2**32-1 and clear on reset.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - typedef port_id_t (1 bit), constants PORT_CPU=0 and PORT_AUX=1;
  - struct rd_tag_t {valid, port, err};
  - function addr_err(addr, AW).
- One sub-module rd_return_pipe: parameterised RD_LAT shift register of rd_tag_t, with synchronous reset clearing all stages.
- Arbitration and memory muxing stay in the top module.

Test Plan:
- Reset, then m0 read addr 0x10 with mem holding 0xDEADBEEF at word 4 → m0_gnt same cycle, mem_addr=4, m0_rvalid RD_LAT cycles later with rdata=0xDEADBEEF.
- m0 and m1 both hold req for 6 cycles, reads → grant sequence 0,1,0,1,0,1; each port gets 3 rvalids; mem_en high all 6 cycles.
- m1 write 0x55 to 0x20, then m0 read 0x20 next cycle → m0_rdata=0x55.
- m0 read 0x22 (misaligned), then m1 write 0x1000 with AW=10 (out of range) → m0_err=1 and m1_err=1 on their grant cycles; mem_en=0 in both cycles; memory unchanged; m0 gets rvalid with rdata=0; last_gnt unchanged.
- Issue a read, assert reset the following cycle → no rvalid on either port afterwards; next conflict grants port 0.
- With DMEM_ARB_PERF_EN defined: 4 conflict cycles plus 2 solo m0 reads → perf_gnt0=4, perf_gnt1=2, perf_conflict=4.
